// File: rtl/data_mem_responder_if.sv
// Processor data-port bus: address, store data, load/store strobes, load data, waitreq.
// Master is the processor; slave is the memory responder.
interface data_mem_responder_if #(
  parameter int unsigned WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] DataAddr;
  logic [WORD_SIZE-1:0] DataOut;
  logic [WORD_SIZE-1:0] DataIn;
  logic                 ReadData;
  logic                 WriteData;
  logic                 DataWaitreq;

  modport master (
    output DataAddr, DataOut, ReadData, WriteData,
    input  DataIn, DataWaitreq
  );

  modport slave (
    input  DataAddr, DataOut, ReadData, WriteData,
    output DataIn, DataWaitreq
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-port responder: RAM plus LED/switch MMIO, one access per LATENCY+1 cycles, sticky error.
// Waitreq is raised combinationally on a request and held LATENCY cycles; completion is the ACK cycle.
module data_mem_responder #(
  parameter int unsigned          WORD_SIZE  = 16,
  parameter int unsigned          ADDR_DEPTH = 256,
  parameter int unsigned          LATENCY    = 2,
  parameter logic [WORD_SIZE-1:0] MMIO_BASE  = 16'hF000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  data_mem_responder_if.slave  dbus,
  input  logic [WORD_SIZE-1:0] SwitchIn,
  output logic [WORD_SIZE-1:0] LedOut,
  output logic                 ErrFlag
);
  localparam int unsigned          AW      = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;
  localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(ADDR_DEPTH);
  localparam logic [WORD_SIZE-1:0] SW_ADDR = MMIO_BASE + WORD_SIZE'(1);
  localparam logic [3:0]           CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]           state;
  logic [3:0]           cnt;
  logic [WORD_SIZE-1:0] cap_addr;
  logic [WORD_SIZE-1:0] cap_data;
  logic                 cap_rd;
  logic                 cap_wr;
  logic [WORD_SIZE-1:0] rdata;
  logic [WORD_SIZE-1:0] ram [ADDR_DEPTH];

  logic                 req;
  logic                 enter_ack;
  logic [WORD_SIZE-1:0] eff_addr;
  logic [WORD_SIZE-1:0] eff_data;
  logic                 eff_rd;
  logic                 eff_wr;
  logic [AW-1:0]        idx;
  logic                 is_ram;
  logic                 is_led;
  logic                 is_sw;
  logic                 bad;
  logic                 err_hit;
  logic [WORD_SIZE-1:0] load_val;

  assign req = dbus.ReadData | dbus.WriteData;

  // With LATENCY==1 capture and commit share one edge, so commit reads the live bus.
  assign eff_addr = (state == IDLE) ? dbus.DataAddr  : cap_addr;
  assign eff_data = (state == IDLE) ? dbus.DataOut   : cap_data;
  assign eff_rd   = (state == IDLE) ? dbus.ReadData  : cap_rd;
  assign eff_wr   = (state == IDLE) ? dbus.WriteData : cap_wr;

  assign enter_ack = !Reset && req &&
                     (((state == IDLE) && (LATENCY == 1)) ||
                      ((state == WAIT) && (cnt == 4'd1)));

  assign idx     = eff_addr[AW-1:0];
  assign is_ram  = eff_addr < DEPTH_W;
  assign is_led  = eff_addr == MMIO_BASE;
  assign is_sw   = eff_addr == SW_ADDR;
  assign bad     = eff_rd & eff_wr;
  assign err_hit = bad | !(is_ram | is_led | is_sw);

  always_comb begin
    load_val = '0;
    if (!bad) begin
      if (is_ram)      load_val = ram[idx];
      else if (is_led) load_val = LedOut;
      else if (is_sw)  load_val = SwitchIn;
    end
  end

  // RAM has no reset so contents survive Reset.
  always_ff @(posedge Clock) begin
    if (enter_ack && eff_wr && !eff_rd && is_ram) ram[idx] <= eff_data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_rd   <= 1'b0;
      cap_wr   <= 1'b0;
      rdata    <= '0;
      LedOut   <= '0;
      ErrFlag  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          cap_addr <= dbus.DataAddr;
          cap_data <= dbus.DataOut;
          cap_rd   <= dbus.ReadData;
          cap_wr   <= dbus.WriteData;
          cnt      <= CNT_INIT;
          state    <= (LATENCY == 1) ? ACK : WAIT;
        end
        WAIT: begin
          if (!req)             state <= IDLE;
          else if (cnt == 4'd1) state <= ACK;
          else                  cnt   <= cnt - 4'd1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (enter_ack) begin
        if (eff_rd && !eff_wr)           rdata   <= load_val;
        if (eff_wr && !eff_rd && is_led) LedOut  <= eff_data;
        if (err_hit)                     ErrFlag <= 1'b1;
      end
    end
  end

  assign dbus.DataWaitreq = !Reset && (((state == IDLE) && req) || (state == WAIT));
  assign dbus.DataIn      = ((state == ACK) && cap_rd && !cap_wr) ? rdata : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 4) driven by directed accesses,
// each checked every cycle against a per-lane behavioural model plus literal expectations.
module tb_data_mem_responder;
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge Clock) cyc++;

  logic        rst  [3];
  logic [15:0] addr [3];
  logic [15:0] wdat [3];
  logic [15:0] sw   [3];
  logic        rd   [3];
  logic        wr   [3];
  logic [15:0] din  [3];
  logic [15:0] led  [3];
  logic        wreq [3];
  logic        err  [3];

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic int lat(input int l);
    return (l == 0) ? 2 : ((l == 1) ? 1 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    data_mem_responder_if #(.WORD_SIZE(16)) bus ();
    assign bus.DataAddr  = addr[g];
    assign bus.DataOut   = wdat[g];
    assign bus.ReadData  = rd[g];
    assign bus.WriteData = wr[g];
    assign din[g]        = bus.DataIn;
    assign wreq[g]       = bus.DataWaitreq;

    data_mem_responder #(
      .WORD_SIZE(16), .ADDR_DEPTH(256), .LATENCY(LAT), .MMIO_BASE(16'hF000)
    ) dut (
      .Clock(Clock), .Reset(rst[g]), .dbus(bus.slave),
      .SwitchIn(sw[g]), .LedOut(led[g]), .ErrFlag(err[g])
    );

    // Model: phase 0 is idle, phase k counts cycles since the access was accepted; phase LAT is the ack cycle.
    logic [15:0] mem   [256];
    bit          known [256];
    int          phase;
    bit          ok;
    logic [15:0] c_addr, c_dat, m_led, m_rdata;
    bit          c_rd, c_wr, m_err, m_rk;
    bit          exp_w;

    initial begin
      ok = 0;
      phase = 0;
      foreach (known[k]) known[k] = 0;
    end

    function automatic void commit();
      if (c_rd && c_wr) begin
        m_err = 1; m_rdata = 16'h0; m_rk = 1;
      end else if (c_addr < 16'd256) begin
        if (c_wr) begin
          mem[c_addr[7:0]] = c_dat; known[c_addr[7:0]] = 1;
        end else begin
          m_rdata = mem[c_addr[7:0]]; m_rk = known[c_addr[7:0]];
        end
      end else if (c_addr == 16'hF000) begin
        if (c_wr) m_led = c_dat;
        else begin m_rdata = m_led; m_rk = 1; end
      end else if (c_addr == 16'hF001) begin
        if (c_rd) begin m_rdata = sw[g]; m_rk = 1; end
      end else begin
        m_err = 1; m_rdata = 16'h0; m_rk = 1;
      end
    endfunction

    always @(posedge Clock) begin
      if (rst[g]) begin
        phase = 0; m_led = 16'h0; m_err = 0; m_rdata = 16'h0; m_rk = 1; ok = 1;
      end else if (phase == 0) begin
        if (rd[g] || wr[g]) begin
          c_addr = addr[g]; c_dat = wdat[g]; c_rd = rd[g]; c_wr = wr[g];
          phase = 1;
          if (phase == LAT) commit();
        end
      end else if (phase < LAT) begin
        if (!(rd[g] || wr[g])) phase = 0;
        else begin
          phase++;
          if (phase == LAT) commit();
        end
      end else begin
        phase = 0;
      end
    end

    always @(negedge Clock) begin
      if (ok) begin
        exp_w = !rst[g] && (((phase == 0) && (rd[g] || wr[g])) || ((phase > 0) && (phase < LAT)));
        check($sformatf("model_waitreq%0d", g), int'(wreq[g]), int'(exp_w));
        if ((phase == LAT) && c_rd && !c_wr) begin
          if (m_rk) check($sformatf("model_datain%0d", g), int'(din[g]), int'(m_rdata));
        end else begin
          check($sformatf("model_datain_zero%0d", g), int'(din[g]), 0);
        end
        check($sformatf("model_led%0d", g), int'(led[g]), int'(m_led));
        check($sformatf("model_err%0d", g), int'(err[g]), int'(m_err));
      end
    end
  end

  // Every access task starts and ends at 1 time unit after a rising edge.
  task automatic access(input int l, input logic [15:0] a, input logic [15:0] d,
                        input bit r, input bit w, input int chg_at, input logic [15:0] alt,
                        input int drop_at, output logic [15:0] got, output int n);
    bit done;
    done = 0;
    got  = 16'h0;
    n    = 0;
    addr[l] = a; wdat[l] = d; rd[l] = r; wr[l] = w;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge Clock);
      if (!wreq[l]) begin got = din[l]; done = 1; end
      else n++;
      @(posedge Clock); #1;
      if (!done && n == drop_at) done = 1;
      if (!done && n == chg_at) addr[l] = alt;
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL access_timeout lane %0d addr %0h", l, a);
    end
    rd[l] = 1'b0; wr[l] = 1'b0;
  endtask

  task automatic st(input int l, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] g; int n;
    access(l, a, d, 1'b0, 1'b1, -1, 16'h0, -1, g, n);
    check($sformatf("store_wait_cycles lane%0d @%0h", l, a), n, lat(l));
  endtask

  task automatic ld(input int l, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] g; int n;
    access(l, a, 16'h0, 1'b1, 1'b0, -1, 16'h0, -1, g, n);
    check($sformatf("load_wait_cycles lane%0d @%0h", l, a), n, lat(l));
    check($sformatf("load_data lane%0d @%0h", l, a), int'(g), int'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] g;
    int n, t0;
    for (int l = 0; l < 3; l++) begin
      rst[l] = 1'b1; addr[l] = 16'h0; wdat[l] = 16'h0; sw[l] = 16'h0; rd[l] = 1'b0; wr[l] = 1'b0;
    end
    @(posedge Clock); #1;
    for (int l = 0; l < 3; l++) rst[l] = 1'b0;
    @(negedge Clock);
    check("reset_waitreq", int'(wreq[0]), 0);
    check("reset_datain",  int'(din[0]),  0);
    check("reset_led",     int'(led[0]),  0);
    check("reset_err",     int'(err[0]),  0);
    @(posedge Clock); #1;

    // Lane 0, LATENCY 2
    st(0, 16'd5, 16'hBEEF);
    ld(0, 16'd5, 16'hBEEF);
    st(0, 16'hF000, 16'h00A5);
    check("led_after_store", int'(led[0]), 16'h00A5);
    sw[0] = 16'h1234;
    ld(0, 16'hF001, 16'h1234);
    st(0, 16'hF001, 16'h5555);
    check("switch_store_no_err", int'(err[0]), 0);
    ld(0, 16'h8000, 16'h0000);
    check("err_after_bad_load", int'(err[0]), 1);
    st(0, 16'h8000, 16'h7777);
    check("err_sticky", int'(err[0]), 1);
    ld(0, 16'd5, 16'hBEEF);

    st(0, 16'd9, 16'h0999);
    access(0, 16'd7, 16'h0777, 1'b0, 1'b1, 1, 16'd9, -1, g, n);
    ld(0, 16'd7, 16'h0777);
    ld(0, 16'd9, 16'h0999);

    addr[0] = 16'd20; wdat[0] = 16'h0001; wr[0] = 1'b1;
    @(negedge Clock);
    check("pre_reset_waitreq", int'(wreq[0]), 1);
    @(posedge Clock); #1;
    rst[0] = 1'b1;
    @(negedge Clock);
    check("waitreq_in_reset", int'(wreq[0]), 0);
    @(posedge Clock); #1;
    rst[0] = 1'b0; wr[0] = 1'b0;
    @(negedge Clock);
    check("led_after_reset", int'(led[0]), 0);
    check("err_after_reset", int'(err[0]), 0);
    @(posedge Clock); #1;
    ld(0, 16'd5, 16'hBEEF);

    st(0, 16'd3, 16'h3333);
    access(0, 16'd3, 16'h9999, 1'b1, 1'b1, -1, 16'h0, -1, g, n);
    check("malformed_data", int'(g), 0);
    check("malformed_wait_cycles", n, 2);
    check("malformed_err", int'(err[0]), 1);
    ld(0, 16'd3, 16'h3333);

    // Lane 1, LATENCY 1: back-to-back stores, no bubble
    t0 = cyc;
    st(1, 16'd0, 16'd1);
    st(1, 16'd1, 16'd2);
    check("b2b_total_cycles", cyc - t0, 4);
    ld(1, 16'd0, 16'd1);
    ld(1, 16'd1, 16'd2);

    // Lane 2, LATENCY 4: abandoned store leaves the word untouched
    st(2, 16'd10, 16'hAAAA);
    access(2, 16'd10, 16'h5555, 1'b0, 1'b1, -1, 16'h0, 2, g, n);
    @(posedge Clock); #1;
    @(negedge Clock);
    check("abort_back_to_idle", int'(wreq[2]), 0);
    @(posedge Clock); #1;
    ld(2, 16'd10, 16'hAAAA);
    check("abort_no_err", int'(err[2]), 0);

    @(posedge Clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
